// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimation datapath: width derivations
// and the block-scheduler FSM encoding.
package me_pkg;

  function automatic int calc_cnt_width(input int tb_length, input int sw_length);
    return $clog2((sw_length - tb_length + 1) ** 2);
  endfunction

  function automatic int calc_sad_width(input int tb_length, input int pe_out_width);
    return $clog2(tb_length ** 2) + pe_out_width;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_STORE   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_FINISH  = 3'd4
  } me_state_t;

endpackage

// File: rtl/me_block_scheduler_if.sv
// Request/acknowledge link between the block scheduler and me_top.
interface me_block_scheduler_if #(
  parameter int SAD_WIDTH = 16,
  parameter int CNT_WIDTH = 12,
  parameter int IDX_WIDTH = 4
);
  // Four-phase level handshake: master raises me_req with blk_idx stable,
  // slave raises me_ack with the result valid, master drops me_req, slave
  // drops me_ack; a new me_req only follows once me_ack is seen low.
  logic                 me_req;
  logic                 me_ack;
  logic [SAD_WIDTH-1:0] me_min_sad;
  logic [CNT_WIDTH-1:0] me_min_mvec;
  logic [IDX_WIDTH-1:0] blk_idx;

  modport master (output me_req, output blk_idx,
                  input  me_ack, input  me_min_sad, input me_min_mvec);
  modport slave  (input  me_req, input  blk_idx,
                  output me_ack, output me_min_sad, output me_min_mvec);
endinterface

// File: rtl/me_result_tracker.sv
// Captures each search result and keeps the per-run total, count and best block.
module me_result_tracker #(
  parameter int SAD_WIDTH = 16,
  parameter int CNT_WIDTH = 12,
  parameter int IDX_WIDTH = 4,
  parameter int TOT_WIDTH = 21
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  input  logic                           capture,
  input  logic                           store,
  input  logic [IDX_WIDTH-1:0]           blk_idx,
  input  logic [SAD_WIDTH-1:0]           sad_in,
  input  logic [CNT_WIDTH-1:0]           mvec_in,
  output logic [SAD_WIDTH+CNT_WIDTH-1:0] wr_data,
  output logic [IDX_WIDTH:0]             blocks_done,
  output logic [TOT_WIDTH-1:0]           total_sad,
  output logic [SAD_WIDTH-1:0]           best_sad,
  output logic [IDX_WIDTH-1:0]           best_idx
);

  logic [SAD_WIDTH-1:0] cap_sad;
  logic [CNT_WIDTH-1:0] cap_mvec;
  logic [SAD_WIDTH-1:0] best_q;
  logic                 have_best;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_sad     <= '0;
      cap_mvec    <= '0;
      best_q      <= '1;
      have_best   <= 1'b0;
      total_sad   <= '0;
      blocks_done <= '0;
      best_idx    <= '0;
    end else begin
      if (capture) begin
        cap_sad  <= sad_in;
        cap_mvec <= mvec_in;
      end
      if (clear) begin
        best_q      <= '1;
        have_best   <= 1'b0;
        total_sad   <= '0;
        blocks_done <= '0;
        best_idx    <= '0;
      end else if (store) begin
        total_sad   <= total_sad + TOT_WIDTH'(cap_sad);
        blocks_done <= blocks_done + (IDX_WIDTH+1)'(1);
        have_best   <= 1'b1;
        // Strict compare: a tie keeps the earlier block.
        if (cap_sad < best_q) begin
          best_q   <= cap_sad;
          best_idx <= blk_idx;
        end
      end
    end
  end

  assign wr_data  = {cap_sad, cap_mvec};
  // The all-ones seed is internal only; the port shows 0 until a block is stored.
  assign best_sad = have_best ? best_q : '0;

endmodule

// File: rtl/me_block_scheduler.sv
// Runs NUM_BLOCKS back-to-back me_top searches, writing each result to the
// result RAM and tracking total/best; supports abort and per-edge timeout.
module me_block_scheduler
  import me_pkg::*;
#(
  parameter int TB_LENGTH      = 16,
  parameter int SW_LENGTH      = 64,
  parameter int PE_OUT_WIDTH   = 8,
  parameter int NUM_BLOCKS     = 16,
  parameter int TIMEOUT_CYCLES = 1048576,
  localparam int CNT_WIDTH = calc_cnt_width(TB_LENGTH, SW_LENGTH),
  localparam int SAD_WIDTH = calc_sad_width(TB_LENGTH, PE_OUT_WIDTH),
  localparam int IDX_WIDTH = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1,
  localparam int TOT_WIDTH = SAD_WIDTH + IDX_WIDTH + 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           abort,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
  output logic                           wr_en,
  output logic [IDX_WIDTH-1:0]           wr_addr,
  output logic [SAD_WIDTH+CNT_WIDTH-1:0] wr_data,
  output logic [IDX_WIDTH:0]             blocks_done,
  output logic [TOT_WIDTH-1:0]           total_sad,
  output logic [SAD_WIDTH-1:0]           best_sad,
  output logic [IDX_WIDTH-1:0]           best_idx,
  output me_state_t                      state_dbg,
  me_block_scheduler_if.master           me_bus
);

  localparam int TMO_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;

  me_state_t            state, state_next;
  logic [IDX_WIDTH-1:0] blk_idx_q;
  logic [TMO_WIDTH-1:0] tmo_cnt;
  logic                 abort_lat;
  logic                 error_q;
  logic                 start_ok, tmo_hit, tmo_evt, last_blk, capture_stb;

  assign start_ok = (state == ST_IDLE) && start && !abort;
  assign tmo_hit  = (tmo_cnt == TMO_WIDTH'(TIMEOUT_CYCLES - 1));
  assign last_blk = (blk_idx_q == IDX_WIDTH'(NUM_BLOCKS - 1));
  // Timeout only counts while waiting on an ack edge that has not arrived.
  assign tmo_evt  = tmo_hit && (((state == ST_REQ) && !me_bus.me_ack) ||
                                ((state == ST_RELEASE) && me_bus.me_ack));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (start_ok) state_next = ST_REQ;
      ST_REQ: begin
        if (me_bus.me_ack) state_next = ST_STORE;
        else if (tmo_evt)  state_next = ST_FINISH;
      end
      ST_STORE:   state_next = ST_RELEASE;
      ST_RELEASE: begin
        if (!me_bus.me_ack) state_next = (last_blk || abort_lat) ? ST_FINISH : ST_REQ;
        else if (tmo_evt)   state_next = ST_FINISH;
      end
      ST_FINISH:  state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state != ST_IDLE);
    done          = (state == ST_FINISH);
    me_bus.me_req = (state == ST_REQ);
    wr_en         = (state == ST_STORE);
    capture_stb   = (state == ST_REQ) && me_bus.me_ack;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt   <= '0;
      blk_idx_q <= '0;
      abort_lat <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      if (state_next != state)  tmo_cnt <= '0;
      else if (tmo_cnt != '1)   tmo_cnt <= tmo_cnt + TMO_WIDTH'(1);

      if (start_ok) blk_idx_q <= '0;
      else if ((state == ST_RELEASE) && (state_next == ST_REQ))
        blk_idx_q <= blk_idx_q + IDX_WIDTH'(1);

      if (start_ok)     error_q <= 1'b0;
      else if (tmo_evt) error_q <= 1'b1;

      // Abort is only honoured at the RELEASE exit so a handshake is never cut.
      if (state_next == ST_IDLE)           abort_lat <= 1'b0;
      else if (abort && state != ST_IDLE)  abort_lat <= 1'b1;
    end
  end

  assign error          = error_q;
  assign wr_addr        = blk_idx_q;
  assign me_bus.blk_idx = blk_idx_q;
  assign state_dbg      = state;

  me_result_tracker #(
    .SAD_WIDTH (SAD_WIDTH),
    .CNT_WIDTH (CNT_WIDTH),
    .IDX_WIDTH (IDX_WIDTH),
    .TOT_WIDTH (TOT_WIDTH)
  ) u_tracker (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (start_ok),
    .capture     (capture_stb),
    .store       (wr_en),
    .blk_idx     (blk_idx_q),
    .sad_in      (me_bus.me_min_sad),
    .mvec_in     (me_bus.me_min_mvec),
    .wr_data     (wr_data),
    .blocks_done (blocks_done),
    .total_sad   (total_sad),
    .best_sad    (best_sad),
    .best_idx    (best_idx)
  );

endmodule

// File: tb/tb_me_block_scheduler.sv
// Bench for me_block_scheduler: me_top ack model, write/done scoreboard,
// handshake timing monitor and directed runs with hand-computed results.
module tb_me_block_scheduler;
  import me_pkg::*;

  localparam int NB     = 4;
  localparam int TMO    = 32;
  localparam int SAD_W  = 16;
  localparam int CNT_W  = 12;
  localparam int IDX_W  = 2;
  localparam int TOT_W  = SAD_W + IDX_W + 1;
  localparam int DATA_W = SAD_W + CNT_W;
  localparam int WR_W   = IDX_W + DATA_W;
  localparam int DONE_W = (IDX_W + 1) + TOT_W + SAD_W + IDX_W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic start = 1'b0;
  logic abort = 1'b0;
  always #5 clk = ~clk;

  logic              busy, done, error, wr_en;
  logic [IDX_W-1:0]  wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [IDX_W:0]    blocks_done;
  logic [TOT_W-1:0]  total_sad;
  logic [SAD_W-1:0]  best_sad;
  logic [IDX_W-1:0]  best_idx;
  me_state_t         state_dbg;

  me_block_scheduler_if #(.SAD_WIDTH(SAD_W), .CNT_WIDTH(CNT_W), .IDX_WIDTH(IDX_W)) bus ();

  me_block_scheduler #(
    .TB_LENGTH(16), .SW_LENGTH(64), .PE_OUT_WIDTH(8),
    .NUM_BLOCKS(NB), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .error(error),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .blocks_done(blocks_done), .total_sad(total_sad),
    .best_sad(best_sad), .best_idx(best_idx),
    .state_dbg(state_dbg), .me_bus(bus)
  );

  // ---------------- shared bench state ----------------
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int req_rises = 0;
  int last_req_len = 0;
  int hs_rises = 0;
  int ack_en = 1;
  int ack_delay = 10;
  int ack_hold = 0;
  int hs_en = 0;
  logic [SAD_W-1:0] sad_tab [NB];
  logic [CNT_W-1:0] mvec_tab [NB];

  logic [WR_W-1:0]   exp_q [$];
  logic [DONE_W-1:0] exp_done_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_tab(input int s0, input int s1, input int s2, input int s3);
    sad_tab[0] = SAD_W'(s0);
    sad_tab[1] = SAD_W'(s1);
    sad_tab[2] = SAD_W'(s2);
    sad_tab[3] = SAD_W'(s3);
  endtask

  task automatic push_writes(input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back({IDX_W'(i), sad_tab[i], mvec_tab[i]});
  endtask

  task automatic push_done(input int bd, input int tot, input int bs, input int bi, input int er);
    exp_done_q.push_back({(IDX_W+1)'(bd), TOT_W'(tot), SAD_W'(bs), IDX_W'(bi), 1'(er)});
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int base;
    base = done_cnt;
    for (int k = 0; k < 2000 && done_cnt == base; k++) @(negedge clk);
    check({name, "_done_seen"}, 64'(done_cnt != base), 64'd1);
  endtask

  // ---------------- me_top ack model ----------------
  initial begin : ack_model
    bus.me_ack      = 1'b0;
    bus.me_min_sad  = '0;
    bus.me_min_mvec = '0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && ack_en != 0 && bus.me_req && !bus.me_ack) begin
        repeat (ack_delay) @(posedge clk);
        #1;
        if (bus.me_req) begin
          bus.me_min_sad  = sad_tab[bus.blk_idx];
          bus.me_min_mvec = mvec_tab[bus.blk_idx];
          bus.me_ack      = 1'b1;
          for (int k = 0; k < 100 && bus.me_req; k++) begin @(posedge clk); #1; end
          repeat (ack_hold) begin @(posedge clk); #1; end
          bus.me_ack = 1'b0;
        end
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  initial begin : monitor
    logic [WR_W-1:0]  e_wr;
    logic [IDX_W:0]   e_bd;
    logic [TOT_W-1:0] e_tot;
    logic [SAD_W-1:0] e_bs;
    logic [IDX_W-1:0] e_bi;
    logic             e_er;
    logic             prev_req, prev_ack, prev2_ack;
    logic [IDX_W-1:0] prev_idx;
    int               req_len;
    prev_req = 1'b0; prev_ack = 1'b0; prev2_ack = 1'b0; prev_idx = '0; req_len = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (wr_en) begin
          check("wr_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e_wr = exp_q.pop_front();
            check("wr_addr", 64'(wr_addr), 64'(e_wr[WR_W-1 -: IDX_W]));
            check("wr_data", 64'(wr_data), 64'(e_wr[DATA_W-1:0]));
          end
        end
        if (done) begin
          done_cnt++;
          check("done_expected", 64'(exp_done_q.size() != 0), 64'd1);
          if (exp_done_q.size() != 0) begin
            {e_bd, e_tot, e_bs, e_bi, e_er} = exp_done_q.pop_front();
            check("blocks_done", 64'(blocks_done), 64'(e_bd));
            check("total_sad",   64'(total_sad),   64'(e_tot));
            check("best_sad",    64'(best_sad),    64'(e_bs));
            check("best_idx",    64'(best_idx),    64'(e_bi));
            check("error",       64'(error),       64'(e_er));
          end
        end
        if (hs_en != 0) begin
          if (bus.me_req && prev_req) check("hs_idx_stable", 64'(bus.blk_idx), 64'(prev_idx));
          if (bus.blk_idx != prev_idx) check("hs_idx_moves_with_req", {bus.me_req, prev_req}, 2'b10);
          if (bus.me_req && !prev_req && bus.blk_idx != '0) begin
            hs_rises++;
            check("hs_req_after_ack_fall", {prev2_ack, prev_ack}, 2'b10);
          end
        end
        if (bus.me_req && !prev_req) req_rises++;
        if (bus.me_req) req_len++;
        else begin
          if (prev_req) last_req_len = req_len;
          req_len = 0;
        end
      end
      prev2_ack = prev_ack;
      prev_ack  = bus.me_ack;
      prev_req  = bus.me_req;
      prev_idx  = bus.blk_idx;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin : stimulus
    int base;
    int found;
    mvec_tab[0] = 12'h0a1;
    mvec_tab[1] = 12'h3f2;
    mvec_tab[2] = 12'h7c3;
    mvec_tab[3] = 12'hfff;
    set_tab(0, 0, 0, 0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {busy, done, error, bus.me_req, wr_en, wr_addr, bus.blk_idx}, '0);
    check("reset_results", {blocks_done, total_sad, best_sad, best_idx}, '0);
    check("reset_wr_data", 64'(wr_data), 64'd0);
    check("reset_state", 64'(state_dbg), 64'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal 4-block run: 300,120,120,500.
    ack_delay = 10; ack_hold = 0;
    set_tab(300, 120, 120, 500);
    push_writes(4);
    push_done(4, 1040, 120, 1, 0);
    pulse_start();
    wait_done("nominal");
    repeat (5) @(negedge clk);
    check("nominal_hold_total", 64'(total_sad), 64'd1040);
    check("nominal_hold_best", 64'(best_sad), 64'd120);
    check("nominal_idle", {busy, done, bus.me_req}, 3'b000);

    // Ack held 5 cycles past req fall, with extra start pulses while busy.
    ack_delay = 3; ack_hold = 5; hs_en = 1; hs_rises = 0;
    set_tab(7, 3, 9, 3);
    push_writes(4);
    push_done(4, 22, 3, 1, 0);
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      repeat (7) @(negedge clk);
      pulse_start();
    end
    wait_done("handshake");
    hs_en = 0;
    check("hs_rises_seen", 64'(hs_rises), 64'd3);

    // Abort during block 1 request.
    ack_delay = 6; ack_hold = 0;
    set_tab(50, 40, 30, 20);
    push_writes(2);
    push_done(2, 90, 40, 1, 0);
    base = req_rises;
    pulse_start();
    found = 0;
    for (int k = 0; k < 500 && found == 0; k++) begin
      @(negedge clk);
      if (bus.me_req && bus.blk_idx == 2'd1) found = 1;
    end
    check("abort_reached_blk1", 64'(found), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done("abort");
    repeat (20) @(negedge clk);
    check("abort_req_count", 64'(req_rises - base), 64'd2);

    // start together with abort: nothing begins, results hold.
    base = req_rises;
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    repeat (5) @(negedge clk);
    check("start_abort_busy", 64'(busy), 64'd0);
    check("start_abort_req_count", 64'(req_rises - base), 64'd0);
    check("start_abort_hold_blocks", 64'(blocks_done), 64'd2);

    // Timeout: ack never rises.
    ack_en = 0;
    push_done(0, 0, 0, 0, 1);
    pulse_start();
    wait_done("timeout");
    check("timeout_req_len", 64'(last_req_len), 64'd32);
    repeat (3) @(negedge clk);
    check("error_sticky", 64'(error), 64'd1);

    // Next start clears error; max-SAD values exercise total width and tie handling.
    ack_en = 1; ack_delay = 2; ack_hold = 0;
    set_tab(65535, 65535, 0, 65535);
    push_writes(4);
    push_done(4, 196605, 0, 2, 0);
    pulse_start();
    repeat (2) @(negedge clk);
    check("error_cleared", 64'(error), 64'd0);
    wait_done("max_sad");

    // Asynchronous reset during STORE of block 2.
    ack_delay = 4; ack_hold = 0;
    set_tab(10, 20, 30, 40);
    push_writes(3);
    pulse_start();
    found = 0;
    for (int k = 0; k < 500 && found == 0; k++) begin
      @(negedge clk);
      if (wr_en && wr_addr == 2'd2) found = 1;
    end
    check("rst_reached_store2", 64'(found), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_ctrl", {busy, done, error, bus.me_req, wr_en, wr_addr, bus.blk_idx}, '0);
    check("rst_mid_results", {blocks_done, total_sad, best_sad, best_idx}, '0);
    check("rst_mid_wr_data", 64'(wr_data), 64'd0);
    check("rst_mid_state", 64'(state_dbg), 64'(ST_IDLE));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Fresh run after reset; equal SADs keep block 0 as best.
    set_tab(5, 5, 5, 5);
    push_writes(4);
    push_done(4, 20, 5, 0, 0);
    pulse_start();
    wait_done("fresh");

    repeat (5) @(negedge clk);
    check("wr_queue_empty", 64'(exp_q.size()), 64'd0);
    check("done_queue_empty", 64'(exp_done_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
